// File: rtl/spi_burst_pkg.sv
// spi_burst_ctrl shared definitions.
// Register map, CTL bits, FSM states.
package spi_burst_pkg;

  localparam logic [2:0] REG_DHI = 3'd0;
  localparam logic [2:0] REG_DLO = 3'd1;
  localparam logic [2:0] REG_CTL = 3'd2;
  localparam logic [2:0] REG_PRE = 3'd3;

  localparam int RDY = 7;
  localparam int SSM = 5;
  localparam int B16 = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_PRE,
    S_W_CTL,
    S_TOK_TX,
    S_DATA_TX,
    S_SETTLE,
    S_POLL_ST,
    S_POLL_DT,
    S_RX_OUT,
    S_DESEL1,
    S_DESEL2,
    S_DONE
  } state_e;

  // CTL byte: manual-SS flag, 8-bit mode, SS lines.
  function automatic logic [7:0] ctl_byte(
    input logic       ssm,
    input logic [1:0] ss
  );
    logic [7:0] b;
    b      = 8'h00;
    b[SSM] = ssm;
    b[B16] = 1'b0;
    b[1:0] = ss;
    return b;
  endfunction

endpackage

// File: rtl/spi_burst_ctrl_reg_port.sv
// Register port sequencer: 1-cycle write,
// 2-cycle read (request, then sample).
module spi_reg_port
  import spi_burst_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [2:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       ack_o,
  output logic [7:0] rdata_o,
  output logic       spi_cs,
  output logic       spi_rw,
  output logic [2:0] spi_ad,
  output logic [7:0] spi_di,
  input  logic [7:0] spi_do
);

  logic rd_ph_q, rd_ph_d;

  // Read phase register: 0 = request, 1 = sample.
  always_ff @(posedge clk) begin
    if (!rst) rd_ph_q <= 1'b0;
    else      rd_ph_q <= rd_ph_d;
  end

  // Drive the peripheral port for the current request.
  always_comb begin
    ack_o   = 1'b0;
    spi_cs  = 1'b0;
    spi_rw  = 1'b0;
    spi_ad  = REG_DHI;
    spi_di  = 8'hFF;
    rd_ph_d = 1'b0;
    if (req_i) begin
      spi_ad = addr_i;
      if (we_i) begin
        spi_cs = 1'b1;
        spi_di = wdata_i;
        ack_o  = 1'b1;
      end else if (!rd_ph_q) begin
        spi_cs  = 1'b1;
        spi_rw  = 1'b1;
        rd_ph_d = 1'b1;
      end else begin
        ack_o = 1'b1;
      end
    end
  end

  assign rdata_o = spi_do;

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer for the SPI register peripheral:
// configure, token wait, data bytes, deselect.
module spi_burst_ctrl
  import spi_burst_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int TMO_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ss_sel,
  input  logic [7:0]       presc,
  input  logic [CNT_W-1:0] len,
  input  logic             wait_tok,
  input  logic [TMO_W-1:0] tmo,
  output logic             busy,
  output logic             done,
  output logic             err_tmo,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             spi_cs,
  output logic             spi_rw,
  output logic [2:0]       spi_ad,
  output logic [7:0]       spi_di,
  input  logic [7:0]       spi_do
);

  localparam int SW = (SETTLE > 1) ?
                      $clog2(SETTLE + 1) : 1;

  state_e           state_q, state_d;
  logic [7:0]       presc_q, presc_d;
  logic [1:0]       ss_q, ss_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SW-1:0]    stl_q, stl_d;
  logic             tok_q, tok_d;
  logic             err_q, err_d;
  logic [7:0]       rx_q, rx_d;

  logic       req, we, ack;
  logic [2:0] addr;
  logic [7:0] wdata, rdata;

  spi_reg_port u_port (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .ack_o   (ack),
    .rdata_o (rdata),
    .spi_cs  (spi_cs),
    .spi_rw  (spi_rw),
    .spi_ad  (spi_ad),
    .spi_di  (spi_di),
    .spi_do  (spi_do)
  );

  // State and command registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      presc_q <= 8'h00;
      ss_q    <= 2'b00;
      rem_q   <= '0;
      tmo_q   <= '0;
      stl_q   <= '0;
      tok_q   <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ss_q    <= ss_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      stl_q   <= stl_d;
      tok_q   <= tok_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
    end
  end

  // Next state, port requests and handshakes.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    ss_d     = ss_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    stl_d    = stl_q;
    tok_d    = tok_q;
    err_d    = err_q;
    rx_d     = rx_q;
    req      = 1'b0;
    we       = 1'b0;
    addr     = REG_DHI;
    wdata    = 8'hFF;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          presc_d = presc;
          ss_d    = ss_sel;
          rem_d   = len;
          tok_d   = wait_tok;
          tmo_d   = tmo;
          err_d   = 1'b0;
          state_d = S_W_PRE;
        end
      end
      S_W_PRE: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = REG_PRE;
        wdata = presc_q;
        if (ack) state_d = S_W_CTL;
      end
      S_W_CTL: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = REG_CTL;
        wdata = ctl_byte(1'b1, ss_q);
        if (ack) begin
          if (tok_q)
            state_d = S_TOK_TX;
          else if (rem_q != '0)
            state_d = S_DATA_TX;
          else
            state_d = S_DESEL1;
        end
      end
      S_TOK_TX: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = REG_DLO;
        wdata = 8'hFF;
        if (ack) state_d = S_SETTLE;
      end
      S_DATA_TX: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          req   = 1'b1;
          we    = 1'b1;
          addr  = REG_DLO;
          wdata = tx_data;
          if (ack) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (stl_q == SW'(SETTLE - 1)) begin
          stl_d   = '0;
          state_d = S_POLL_ST;
        end else begin
          stl_d = stl_q + SW'(1);
        end
      end
      S_POLL_ST: begin
        req  = 1'b1;
        addr = REG_CTL;
        if (ack && rdata[RDY])
          state_d = S_POLL_DT;
      end
      S_POLL_DT: begin
        req  = 1'b1;
        addr = REG_DLO;
        if (ack) begin
          rx_d = rdata;
          if (!tok_q) begin
            state_d = S_RX_OUT;
          end else if (rdata != 8'hFF) begin
            state_d = S_RX_OUT;
          end else if (tmo_q == '0) begin
            err_d   = 1'b1;
            tok_d   = 1'b0;
            state_d = S_DESEL1;
          end else begin
            tmo_d   = tmo_q - TMO_W'(1);
            state_d = S_TOK_TX;
          end
        end
      end
      S_RX_OUT: begin
        rx_valid = 1'b1;
        if (rx_ready) begin
          if (tok_q) begin
            tok_d = 1'b0;
            if (rem_q != '0)
              state_d = S_DATA_TX;
            else
              state_d = S_DESEL1;
          end else begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1))
              state_d = S_DESEL1;
            else
              state_d = S_DATA_TX;
          end
        end
      end
      S_DESEL1: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = REG_CTL;
        wdata = ctl_byte(1'b1, 2'b11);
        if (ack) state_d = S_DESEL2;
      end
      S_DESEL2: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = REG_CTL;
        wdata = ctl_byte(1'b0, 2'b11);
        if (ack) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) &&
                   (state_q != S_DONE);
  assign err_tmo = err_q;
  assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Random + directed bench for spi_burst_ctrl
// against a transaction-level peripheral model.
module tb_spi_burst_ctrl;

  localparam int CNT_W  = 10;
  localparam int TMO_W  = 16;
  localparam int SETTLE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       ss_sel = 2'b00;
  logic [7:0]       presc = 8'h00;
  logic [CNT_W-1:0] len = '0;
  logic             wait_tok = 1'b0;
  logic [TMO_W-1:0] tmo = '0;
  logic             busy, done, err_tmo;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       tx_data = 8'h00;
  logic             rx_valid;
  logic             rx_ready = 1'b0;
  logic [7:0]       rx_data;
  logic             spi_cs, spi_rw;
  logic [2:0]       spi_ad;
  logic [7:0]       spi_di;
  logic [7:0]       spi_do = 8'h00;

  always #5 clk = ~clk;

  spi_burst_ctrl #(
    .CNT_W  (CNT_W),
    .TMO_W  (TMO_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ss_sel   (ss_sel),
    .presc    (presc),
    .len      (len),
    .wait_tok (wait_tok),
    .tmo      (tmo),
    .busy     (busy),
    .done     (done),
    .err_tmo  (err_tmo),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .spi_cs   (spi_cs),
    .spi_rw   (spi_rw),
    .spi_ad   (spi_ad),
    .spi_di   (spi_di),
    .spi_do   (spi_do)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               tag, act, exp);
    end
  endtask

  // Bench-side observation and stimulus state.
  int wlog_a[$];
  int wlog_d[$];
  int rxlog[$];
  int resp_q[$];
  int tx_list[$];
  int done_cyc[$];
  int exp_a[$];
  int exp_d[$];
  int exp_rx[$];
  int exp_err, exp_ntx;
  int ncyc = 0;
  int shift_cnt = 0;
  int shift_rx = 0;
  int dw_cnt = 0;
  int tx_idx = 0;
  int start_cyc = -1;
  int first_dw = -1;
  int last_rxhs = -1;
  int busy_done = 0;
  int err_done = 0;
  int tx_p = 100;
  int rx_p = 100;
  logic stall = 1'b0;

  // Peripheral model and monitor, away from posedge.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (spi_cs && !spi_rw) begin
        wlog_a.push_back(int'(spi_ad));
        wlog_d.push_back(int'(spi_di));
        if (spi_ad == 3'd1) begin
          dw_cnt++;
          if (first_dw < 0) first_dw = ncyc;
          if (resp_q.size() > 0)
            shift_rx = resp_q.pop_front();
          else
            shift_rx = int'(~spi_di);
          shift_cnt = $urandom_range(6, 0);
        end
      end else if (shift_cnt > 0) begin
        shift_cnt--;
      end
      if (spi_cs && spi_rw) begin
        if (spi_ad == 3'd2)
          spi_do = (shift_cnt == 0) ?
                   8'h80 : 8'h00;
        else
          spi_do = shift_rx[7:0];
      end
      if (tx_valid && tx_ready) tx_idx++;
      if (rx_valid && rx_ready) begin
        rxlog.push_back(int'(rx_data));
        last_rxhs = ncyc;
      end
      if (start && start_cyc < 0)
        start_cyc = ncyc;
      if (done) begin
        done_cyc.push_back(ncyc);
        busy_done = int'(busy);
        err_done  = int'(err_tmo);
      end
    end
  end

  // Source and sink handshakes, just after posedge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_idx < tx_list.size()) begin
        tx_valid = ($urandom_range(99, 0) < tx_p);
        tx_data  = tx_list[tx_idx][7:0];
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
      rx_ready = !stall &&
                 ($urandom_range(99, 0) < rx_p);
    end
  end

  // Reference: what the peripheral returns per byte.
  function automatic int miso(inout int r[$],
                              input int tx);
    if (r.size() > 0) return r.pop_front();
    return (~tx) & 8'hFF;
  endfunction

  // Expected transactions from the command alone.
  task automatic build_exp(input int p, input int s,
                           input int l, input int w,
                           input int t);
    int r[$];
    int b;
    int found;
    r = resp_q;
    exp_a = {};
    exp_d = {};
    exp_rx = {};
    exp_err = 0;
    exp_a.push_back(3); exp_d.push_back(p);
    exp_a.push_back(2); exp_d.push_back(32 + s);
    if (w != 0) begin
      found = 0;
      for (int k = 0; k <= t && found == 0; k++) begin
        exp_a.push_back(1); exp_d.push_back(255);
        b = miso(r, 255);
        if (b != 255) begin
          found = 1;
          exp_rx.push_back(b);
        end
      end
      if (found == 0) exp_err = 1;
    end
    exp_ntx = (exp_err != 0) ? 0 : l;
    for (int i = 0; i < exp_ntx; i++) begin
      exp_a.push_back(1);
      exp_d.push_back(tx_list[i]);
      exp_rx.push_back(miso(r, tx_list[i]));
    end
    exp_a.push_back(2); exp_d.push_back(8'h23);
    exp_a.push_back(2); exp_d.push_back(8'h03);
  endtask

  task automatic begin_burst(input int p, input int s,
                             input int l, input int w,
                             input int t);
    build_exp(p, s, l, w, t);
    wlog_a = {};
    wlog_d = {};
    rxlog = {};
    done_cyc = {};
    start_cyc = -1;
    first_dw = -1;
    last_rxhs = -1;
    tx_idx = 0;
    dw_cnt = 0;
    shift_cnt = 0;
    @(posedge clk);
    #1;
    start    = 1'b1;
    presc    = p[7:0];
    ss_sel   = s[1:0];
    len      = l[CNT_W-1:0];
    wait_tok = (w != 0);
    tmo      = t[TMO_W-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_burst(input string nm);
    int n;
    int m;
    n = 0;
    while (done_cyc.size() == 0 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, "_done_seen"},
          int'(done_cyc.size() > 0), 1);
    repeat (4) @(posedge clk);
    #1;
    check({nm, "_done_pulses"}, done_cyc.size(), 1);
    check({nm, "_busy_at_done"}, busy_done, 0);
    check({nm, "_err_tmo"}, err_done, exp_err);
    check({nm, "_idle_busy"}, int'(busy), 0);
    check({nm, "_tx_used"}, tx_idx, exp_ntx);
    check({nm, "_nwr"}, wlog_a.size(), exp_a.size());
    m = (wlog_a.size() < exp_a.size()) ?
        wlog_a.size() : exp_a.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_wr%0d", nm, i),
            wlog_a[i] * 256 + wlog_d[i],
            exp_a[i] * 256 + exp_d[i]);
    check({nm, "_nrx"}, rxlog.size(), exp_rx.size());
    m = (rxlog.size() < exp_rx.size()) ?
        rxlog.size() : exp_rx.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_rx%0d", nm, i),
            rxlog[i], exp_rx[i]);
  endtask

  task automatic wait_until_rx(input int k);
    int n;
    n = 0;
    while (rxlog.size() < k && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("reach_rx%0d", k),
          int'(rxlog.size() >= k), 1);
  endtask

  initial begin
    int snap;
    int n;
    int l;
    int w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err_tmo), 0);
    check("rst_txr", int'(tx_ready), 0);
    check("rst_rxv", int'(rx_valid), 0);
    check("rst_cs", int'(spi_cs), 0);
    check("rst_rw", int'(spi_rw), 0);
    check("rst_ad", int'(spi_ad), 0);
    check("rst_di", int'(spi_di), 8'hFF);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Plain 3-byte burst with echo-inverted MISO.
    tx_list = '{8'h40, 8'h00, 8'h95};
    resp_q = {};
    begin_burst(2, 2, 3, 0, 0);
    finish_burst("t1");
    check("t1_first_dw", first_dw - start_cyc, 3);
    check("t1_rx_to_done",
          done_cyc.size() > 0 ?
          done_cyc[0] - last_rxhs : -1, 3);

    // Token found on the third try; stray start ignored.
    tx_list = '{8'h11, 8'h22};
    resp_q = '{8'hFF, 8'hFF, 8'hFE};
    begin_burst(5, 1, 2, 1, 5);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    presc = 8'h77;
    len   = 10'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_burst("t2");

    // Token never arrives: tmo+1 tries, then error.
    tx_list = '{8'h33};
    resp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    begin_burst(7, 3, 1, 1, 3);
    finish_burst("t3");
    check("t3_err_held", int'(err_tmo), 1);

    // RX backpressure after the second byte.
    tx_list = '{8'h01, 8'h02, 8'h03, 8'h04};
    resp_q = {};
    begin_burst(1, 0, 4, 0, 0);
    wait_until_rx(2);
    stall = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    snap = dw_cnt;
    check("stall_dw", snap, 3);
    check("stall_rxv", int'(rx_valid), 1);
    repeat (30) @(posedge clk);
    #1;
    check("stall_nowr", dw_cnt, snap);
    check("stall_nrx", rxlog.size(), 2);
    check("stall_err_clr", int'(err_tmo), 0);
    stall = 1'b0;
    finish_burst("t4");

    // Reset during SETTLE of the second byte.
    tx_list = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    resp_q = {};
    begin_burst(3, 2, 4, 0, 0);
    n = 0;
    while (dw_cnt < 2 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_reach", int'(dw_cnt >= 2), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_cs", int'(spi_cs), 0);
    check("rst_mid_txr", int'(tx_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tx_list = '{8'h5A, 8'hC3};
    begin_burst(4, 1, 2, 0, 0);
    finish_burst("t5");

    // Empty burst: config, deselect, done.
    tx_list = {};
    resp_q = {};
    begin_burst(9, 2, 0, 0, 0);
    finish_burst("t6");
    check("t6_start_to_done",
          done_cyc.size() > 0 ?
          done_cyc[0] - start_cyc : -1, 5);

    // Randomized bursts.
    for (int it = 0; it < 20; it++) begin
      tx_p = $urandom_range(100, 30);
      rx_p = $urandom_range(100, 30);
      l = $urandom_range(5, 0);
      w = $urandom_range(1, 0);
      tx_list = {};
      for (int i = 0; i < l; i++)
        tx_list.push_back($urandom_range(255, 0));
      resp_q = {};
      n = $urandom_range(5, 0);
      for (int i = 0; i < n; i++)
        resp_q.push_back(
          ($urandom_range(99, 0) < 60) ?
          255 : $urandom_range(255, 0));
      begin_burst($urandom_range(255, 0),
                  $urandom_range(3, 0), l, w,
                  $urandom_range(3, 0));
      finish_burst($sformatf("r%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
